tpu_batch_ctrl: RTL and testbench
=================================

TPU_BATCH_CTRL -- requirements
Module: tpu_batch_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 256: width of one buffer row (A, B and result).
REQ-002 SHALL have parameter DEPTH, default 32: rows per buffer; a power of two, 2..256.
REQ-003 SHALL have derived localparam CNT_W = $clog2(DEPTH)+1: width of row counts and pointers.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  A/B load beat valid.
REQ-007 in_ready  out  1  load beat accepted when in_valid && in_ready.
REQ-008 in_a, in_b  in  WORD_W each  A row and B row of the load beat.
REQ-009 rows_in  in  CNT_W  number of A/B rows in this job; sampled on the first accepted beat only.
REQ-010 rows_out  in  CNT_W  number of result rows in this job; sampled on the first accepted beat only.
REQ-011 tpu_in_valid  out  1  operand row to the TPU core is valid.
REQ-012 tpu_in_ready  in  1  TPU core accepts the operand row.
REQ-013 tpu_a, tpu_b  out  WORD_W each  operand rows to the TPU core.
REQ-014 tpu_out_valid  in  1  TPU core result row is valid.
REQ-015 tpu_out_ready  out  1  this block accepts the TPU core result row.
REQ-016 tpu_out  in  WORD_W  TPU core result row.
REQ-017 out_valid  out  1  result row valid; registered.
REQ-018 out_ready  in  1  downstream consumer accepts the result row.
REQ-019 out_data  out  WORD_W  result row; registered.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse at end of job.

Function
REQ-022 FSM states SHALL be IDLE, LOAD, FEED, COLLECT, DRAIN, DONE.
REQ-023 Row counts: a sampled value of 0 or a value above DEPTH SHALL be treated as DEPTH. Call the results N_in and N_out.
REQ-024 IDLE: in_ready=1; a handshake latches N_in/N_out, writes A[0]/B[0], then -> LOAD, or -> FEED if N_in==1.
REQ-025 LOAD: in_ready=1; beat i writes A[i]/B[i]; the handshake writing row N_in-1 -> FEED.
REQ-026 in_ready SHALL be 0 in FEED, COLLECT, DRAIN and DONE; in_valid in those states is ignored and nothing is written.
REQ-027 FEED: tpu_in_valid=1; tpu_a/tpu_b = A[rd_ptr]/B[rd_ptr], combinational read.
REQ-028 FEED: rd_ptr advances only on the tpu handshake; operands SHALL stay stable while tpu_in_ready=0.
REQ-029 FEED: after N_in handshakes -> COLLECT.
REQ-030 tpu_in_valid SHALL be 0 and tpu_a/tpu_b SHALL be 0 outside FEED.
REQ-031 COLLECT: tpu_out_ready=1; each handshake writes tpu_out into O[wr_ptr], wr_ptr+1; after N_out handshakes -> DRAIN.
REQ-032 tpu_out_ready SHALL be 0 outside COLLECT; tpu_out_valid outside COLLECT is ignored.
REQ-033 DRAIN: output register loads O[dr_ptr] whenever !out_valid || out_ready, until N_out rows have been loaded.
REQ-034 First out_valid SHALL rise exactly 1 cycle after DRAIN entry.
REQ-035 out_data SHALL hold while out_valid && !out_ready.
REQ-036 After the N_out-th output handshake -> DONE: out_valid=0, done=1 for one cycle, then -> IDLE.
REQ-037 With out_ready held 1, DRAIN SHALL emit one row per cycle with no bubbles.
REQ-038 Back-to-back jobs: IDLE SHALL accept a new first beat on the cycle after DONE.
REQ-039 Pointer and counter arithmetic SHALL be unsigned CNT_W-bit with no wrap-around; they reset to 0 on entry to each state.

Reset
REQ-040 On rst_n low, from any state: state=IDLE and all pointers/counts=0.
REQ-041 On rst_n low: out_valid=0, out_data=0, done=0, busy=0.
REQ-042 On rst_n low: in_ready=1 once reset releases, tpu_in_valid=0, tpu_out_ready=0.
REQ-043 Buffer arrays SHALL NOT be reset; their contents after reset are don't-care.
REQ-044 Reset mid-job SHALL abandon the job; no done pulse is produced for it.

Structure
REQ-045 State encoding and default WORD_W/DEPTH SHALL live in the shared define package alongside ROW_SIZE/WORD_SIZE.
REQ-046 A single parametrised sub-module gbuf_row (WORD_W, DEPTH) SHALL provide the buffers, instantiated three times (A, B, O).
REQ-047 gbuf_row SHALL have a synchronous write port and a combinational read port.

Verification
REQ-048 Full job: DEPTH=32, rows_in=rows_out=32, TPU model with zero stalls and out_ready=1 -> 32 operand handshakes in order, 32 output rows equal to the model results, one done pulse.
REQ-049 Backpressure: out_ready toggled randomly -> out_data stable while stalled, no row lost or duplicated.
REQ-050 TPU stalls: tpu_in_ready=0 for 5 cycles in the middle of FEED -> tpu_a/tpu_b held, rd_ptr not advanced.
REQ-051 Size boundaries: rows_in=1,rows_out=1 -> IDLE->FEED directly, one output row; rows_in=0 -> 32 rows loaded.
REQ-052 Reset at DRAIN row 10 -> out_valid=0 next cycle, state IDLE, new job runs correctly.
REQ-053 in_valid held high during FEED/COLLECT/DRAIN -> in_ready=0 and A/B buffer contents unchanged.

Source files
------------

// File: rtl/tpu_batch_ctrl_pkg.sv
// rtl/tpu_batch_ctrl_pkg.sv - shared defines for the TPU batch controller
package tpu_batch_ctrl_pkg;

  // Native geometry of the systolic array this controller feeds
  localparam int WORD_SIZE = 256;
  localparam int ROW_SIZE  = 32;

  localparam int DEF_WORD_W = WORD_SIZE;
  localparam int DEF_DEPTH  = ROW_SIZE;

  // Controller state encoding
  localparam int ST_W = 3;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_FEED    = 3'd2;
  localparam logic [2:0] ST_COLLECT = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/tpu_batch_ctrl_gbuf_row.sv
// rtl/tpu_batch_ctrl_gbuf_row.sv - row buffer with sync write and combinational read
module gbuf_row
  import tpu_batch_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  // Contents are not reset; every row is written before it is read in a job
  logic [WORD_W-1:0] mem [DEPTH];

  // Write one row on the rising edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tpu_batch_ctrl.sv
// rtl/tpu_batch_ctrl.sv - load / feed / collect / drain sequencer for one TPU job
module tpu_batch_ctrl
  import tpu_batch_ctrl_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int DEPTH   = DEF_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic [CNT_W-1:0]  rows_in,
  input  logic [CNT_W-1:0]  rows_out,
  output logic              tpu_in_valid,
  input  logic              tpu_in_ready,
  output logic [WORD_W-1:0] tpu_a,
  output logic [WORD_W-1:0] tpu_b,
  input  logic              tpu_out_valid,
  output logic              tpu_out_ready,
  input  logic [WORD_W-1:0] tpu_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);

  // Zero or oversized requests mean "use the whole buffer"
  function automatic logic [CNT_W-1:0] norm_rows(input logic [CNT_W-1:0] v);
    if (v == '0 || v > CNT_W'(DEPTH)) begin
      return CNT_W'(DEPTH);
    end
    return v;
  endfunction

  logic [ST_W-1:0]   state;
  logic [CNT_W-1:0]  n_in;
  logic [CNT_W-1:0]  n_out;
  logic [CNT_W-1:0]  ld_ptr;   // LOAD beats taken after the first row
  logic [CNT_W-1:0]  rd_ptr;   // FEED operand row
  logic [CNT_W-1:0]  wr_ptr;   // COLLECT result row
  logic [CNT_W-1:0]  dr_ptr;   // DRAIN rows moved into the output register
  logic [CNT_W-1:0]  oc_cnt;   // DRAIN rows handed downstream

  logic [CNT_W-1:0]  rows_in_n;
  logic [CNT_W-1:0]  rows_out_n;
  logic [AW-1:0]     ld_addr;
  logic [WORD_W-1:0] buf_a_rd;
  logic [WORD_W-1:0] buf_b_rd;
  logic [WORD_W-1:0] buf_o_rd;

  logic in_fire;
  logic feed_fire;
  logic col_fire;
  logic out_fire;
  logic dr_load;

  assign rows_in_n  = norm_rows(rows_in);
  assign rows_out_n = norm_rows(rows_out);

  assign in_ready      = (state == ST_IDLE) || (state == ST_LOAD);
  assign tpu_in_valid  = (state == ST_FEED);
  assign tpu_out_ready = (state == ST_COLLECT);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);

  assign in_fire   = in_valid && in_ready;
  assign feed_fire = tpu_in_valid && tpu_in_ready;
  assign col_fire  = tpu_out_valid && tpu_out_ready;
  assign out_fire  = out_valid && out_ready;

  // The output register refills whenever it is empty or being emptied
  assign dr_load = (state == ST_DRAIN) && (dr_ptr != n_out) && (!out_valid || out_ready);

  // Row 0 is written from IDLE; LOAD beat k writes row k+1
  assign ld_addr = (state == ST_LOAD) ? ld_ptr[AW-1:0] + AW'(1) : '0;

  assign tpu_a = (state == ST_FEED) ? buf_a_rd : '0;
  assign tpu_b = (state == ST_FEED) ? buf_b_rd : '0;

  gbuf_row #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_buf_a (
    .clk   (clk),
    .we    (in_fire),
    .waddr (ld_addr),
    .wdata (in_a),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (buf_a_rd)
  );

  gbuf_row #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_buf_b (
    .clk   (clk),
    .we    (in_fire),
    .waddr (ld_addr),
    .wdata (in_b),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (buf_b_rd)
  );

  gbuf_row #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_buf_o (
    .clk   (clk),
    .we    (col_fire),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (tpu_out),
    .raddr (dr_ptr[AW-1:0]),
    .rdata (buf_o_rd)
  );

  // Job sequencer: state plus the per-phase pointers, each cleared on phase entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      n_in   <= '0;
      n_out  <= '0;
      ld_ptr <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      dr_ptr <= '0;
      oc_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            n_in   <= rows_in_n;
            n_out  <= rows_out_n;
            ld_ptr <= '0;
            rd_ptr <= '0;
            state  <= (rows_in_n == CNT_W'(1)) ? ST_FEED : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_fire) begin
            if (ld_ptr == n_in - CNT_W'(2)) begin
              ld_ptr <= '0;
              rd_ptr <= '0;
              state  <= ST_FEED;
            end else begin
              ld_ptr <= ld_ptr + CNT_W'(1);
            end
          end
        end
        ST_FEED: begin
          if (feed_fire) begin
            if (rd_ptr == n_in - CNT_W'(1)) begin
              rd_ptr <= '0;
              wr_ptr <= '0;
              state  <= ST_COLLECT;
            end else begin
              rd_ptr <= rd_ptr + CNT_W'(1);
            end
          end
        end
        ST_COLLECT: begin
          if (col_fire) begin
            if (wr_ptr == n_out - CNT_W'(1)) begin
              wr_ptr <= '0;
              dr_ptr <= '0;
              oc_cnt <= '0;
              state  <= ST_DRAIN;
            end else begin
              wr_ptr <= wr_ptr + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (dr_load) begin
            dr_ptr <= dr_ptr + CNT_W'(1);
          end
          if (out_fire) begin
            if (oc_cnt == n_out - CNT_W'(1)) begin
              dr_ptr <= '0;
              oc_cnt <= '0;
              state  <= ST_DONE;
            end else begin
              oc_cnt <= oc_cnt + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered result stage: refill from O, hold under backpressure, empty outside DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (state == ST_DRAIN) begin
      if (dr_load) begin
        out_valid <= 1'b1;
        out_data  <= buf_o_rd;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tpu_batch_ctrl.sv
// tb/tb_tpu_batch_ctrl.sv - directed self-checking bench for tpu_batch_ctrl
module tb_tpu_batch_ctrl;
  import tpu_batch_ctrl_pkg::*;

  localparam int WORD_W = 256;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_a;
  logic [WORD_W-1:0] in_b;
  logic [CNT_W-1:0]  rows_in;
  logic [CNT_W-1:0]  rows_out;
  logic              tpu_in_valid;
  logic              tpu_in_ready;
  logic [WORD_W-1:0] tpu_a;
  logic [WORD_W-1:0] tpu_b;
  logic              tpu_out_valid;
  logic              tpu_out_ready;
  logic [WORD_W-1:0] tpu_out;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int job_id   = 0;

  tpu_batch_ctrl #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .rows_in       (rows_in),
    .rows_out      (rows_out),
    .tpu_in_valid  (tpu_in_valid),
    .tpu_in_ready  (tpu_in_ready),
    .tpu_a         (tpu_a),
    .tpu_b         (tpu_b),
    .tpu_out_valid (tpu_out_valid),
    .tpu_out_ready (tpu_out_ready),
    .tpu_out       (tpu_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Count done cycles as seen by the clock edge
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] sa(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 ^ 32'(job_id << 16) ^ 32'(i);
    return {8{w}};
  endfunction

  function automatic logic [WORD_W-1:0] sb(input int i);
    logic [31:0] w;
    w = 32'h3C00_0000 ^ 32'(job_id << 16) ^ 32'(i * 7 + 1);
    return {w, 32'h0, ~w, 32'h1, w, 32'h2, ~w, 32'h3};
  endfunction

  // TPU core model: result row j combines operand row j mod N_in with its index
  function automatic logic [WORD_W-1:0] res(input int j, input int nin);
    return (sa(j % nin) + sb(j % nin)) ^ WORD_W'(j);
  endfunction

  function automatic int norm(input int r);
    return (r == 0 || r > DEPTH) ? DEPTH : r;
  endfunction

  // One complete job; called and returns on a falling edge
  task automatic run_job(input int req_in, input int req_out, input bit stall,
                         input bit bp, input bit hold, input int reset_at);
    int nin, nout, cnt, cyc, st, k, c, bubbles, base;
    bit r, v, stalled;
    logic [WORD_W-1:0] prev;
    nin  = norm(req_in);
    nout = norm(req_out);
    base = done_cnt;
    // Load: later beats carry bogus counts, which must be ignored
    for (int i = 0; i < nin; i++) begin
      chk("load_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      in_a     = sa(i);
      in_b     = sb(i);
      rows_in  = (i == 0) ? CNT_W'(req_in) : CNT_W'(3);
      rows_out = (i == 0) ? CNT_W'(req_out) : CNT_W'(3);
      @(negedge clk);
    end
    in_valid = hold;
    in_a     = {8{32'hDEAD_BEEF}};
    in_b     = {8{32'hBAD0_F00D}};
    chk("feed_state", dut.state, ST_FEED);
    chk("feed_in_ready", in_ready, 1'b0);
    // Feed
    cnt = 0; cyc = 0; st = 0;
    while (cnt < nin && cyc < 1000) begin
      chk("feed_valid", tpu_in_valid, 1'b1);
      if (stall && cnt == nin / 2 && st < 5) begin
        tpu_in_ready = 1'b0;
        chk("stall_a", tpu_a, sa(cnt));
        chk("stall_b", tpu_b, sb(cnt));
        chk("stall_rd_ptr", dut.rd_ptr, cnt);
        st++;
      end else begin
        tpu_in_ready = 1'b1;
        chk("feed_a", tpu_a, sa(cnt));
        chk("feed_b", tpu_b, sb(cnt));
        cnt++;
      end
      cyc++;
      @(negedge clk);
    end
    if (cnt < nin) chk("feed_timeout", cnt, nin);
    tpu_in_ready = 1'b0;
    chk("collect_tpu_valid", tpu_in_valid, 1'b0);
    chk("collect_tpu_a", tpu_a, '0);
    chk("collect_in_ready", in_ready, 1'b0);
    // Collect
    cnt = 0; cyc = 0;
    while (cnt < nout && cyc < 1000) begin
      chk("collect_ready", tpu_out_ready, 1'b1);
      v = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      tpu_out_valid = v;
      tpu_out       = res(cnt, nin);
      if (v) cnt++;
      cyc++;
      @(negedge clk);
    end
    if (cnt < nout) chk("collect_timeout", cnt, nout);
    tpu_out_valid = 1'b0;
    tpu_out       = {8{32'h5555_AAAA}};
    // Drain
    k = 0; c = 0; bubbles = 0; stalled = 1'b0; prev = '0;
    while (k < nout && c < 2000) begin
      if (c == 0) chk("drain_first_c0", out_valid, 1'b0);
      if (c == 1) chk("drain_first_c1", out_valid, 1'b1);
      if (stalled) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev);
      end
      if (reset_at >= 0 && k == reset_at) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_state", dut.state, ST_IDLE);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tpu_out_ready", tpu_out_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_no_done", done_cnt, base);
        return;
      end
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (!bp && c >= 1 && !out_valid) bubbles++;
      if (out_valid && r) begin
        chk("out_row", out_data, res(k, nin));
        k++;
      end
      stalled = out_valid && !r;
      prev    = out_data;
      c++;
      @(negedge clk);
    end
    if (k < nout) chk("drain_timeout", k, nout);
    if (!bp) chk("drain_bubbles", bubbles, 0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("done_out_valid", out_valid, 1'b0);
    if (hold) begin
      chk("a_kept_0", dut.u_buf_a.mem[0], sa(0));
      chk("b_kept_last", dut.u_buf_b.mem[nin-1], sb(nin - 1));
    end
    @(negedge clk);
    chk("idle_done_low", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("done_count", done_cnt, base + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; rows_in = '0; rows_out = '0;
    tpu_in_ready = 1'b0; tpu_out_valid = 1'b0; tpu_out = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, '0);
    chk("reset_done", done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_tpu_in_valid", tpu_in_valid, 1'b0);
    chk("reset_tpu_out_ready", tpu_out_ready, 1'b0);
    chk("reset_tpu_a", tpu_a, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);

    job_id = 1; run_job(32, 32, 1'b0, 1'b0, 1'b0, -1);
    job_id = 2; run_job(8, 12, 1'b1, 1'b1, 1'b1, -1);
    job_id = 3; run_job(1, 1, 1'b0, 1'b0, 1'b0, -1);
    job_id = 4; run_job(0, 3, 1'b0, 1'b0, 1'b1, -1);
    job_id = 5; run_job(16, 20, 1'b0, 1'b0, 1'b0, 10);
    job_id = 6; run_job(5, 40, 1'b1, 1'b1, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
